// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// Scans digit 0 (rightmost) to digit 3, opens every digit slot with an
// all-off blank window against ghosting, and only swaps the shown value at
// frame boundaries so a digit never mixes old and new data within a frame.
module seven_seg_scan_driver #(
    parameter int unsigned REFRESH_CYCLES = 125_000,
    parameter int unsigned BLANK_CYCLES   = 1_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] value_in,
    input  logic        value_valid,
    input  logic        blank_lz,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        frame_done
);

    localparam int unsigned CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       digit_q, digit_d;
    logic [15:0]      disp_q, disp_d;
    logic [15:0]      pend_q, pend_d;
    logic             flag_q, flag_d;
    logic [6:0]       seg_q, seg_d;
    logic [3:0]       an_q, an_d;
    logic             fd_q, fd_d;

    logic             slot_end_c;
    logic             frame_end_c;
    logic             lz_hide_c;
    logic [3:0]       nibble_c;

    // Active-low hex font, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = fd_q;

    assign slot_end_c  = (cnt_q == CNT_LAST);
    assign frame_end_c = slot_end_c && (digit_q == 2'd3);
    assign nibble_c    = disp_q[{digit_q, 2'b00} +: 4];

    // A digit is a leading zero when it and every more significant nibble are zero.
    always_comb begin
        lz_hide_c = 1'b0;
        case (digit_q)
            2'd1:    lz_hide_c = (disp_q[15:4]  == 12'h000);
            2'd2:    lz_hide_c = (disp_q[15:8]  == 8'h00);
            2'd3:    lz_hide_c = (disp_q[15:12] == 4'h0);
            default: lz_hide_c = 1'b0;
        endcase
    end

    // State, scan position, value registers and registered pin drivers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_BLANK;
            cnt_q   <= '0;
            digit_q <= 2'd0;
            disp_q  <= 16'h0000;
            pend_q  <= 16'h0000;
            flag_q  <= 1'b0;
            seg_q   <= 7'h7F;
            an_q    <= 4'hF;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            digit_q <= digit_d;
            disp_q  <= disp_d;
            pend_q  <= pend_d;
            flag_q  <= flag_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            fd_q    <= fd_d;
        end
    end

    // Next-state: slot sequencing, frame-boundary value transfer and pin values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        digit_d = digit_q;
        disp_d  = disp_q;
        pend_d  = pend_q;
        flag_d  = flag_q;
        seg_d   = 7'h7F;
        an_d    = 4'hF;
        fd_d    = 1'b0;

        if (value_valid) begin
            pend_d = value_in;
            flag_d = 1'b1;
        end

        if (!enable) begin
            // Parked dark at the start of a frame; track the newest value.
            state_d = ST_BLANK;
            cnt_d   = '0;
            digit_d = 2'd0;
            disp_d  = value_valid ? value_in : pend_q;
            flag_d  = 1'b0;
        end else begin
            if (state_q == ST_DRIVE) begin
                an_d  = ~(4'b0001 << digit_q);
                seg_d = (blank_lz && lz_hide_c) ? 7'h7F : hex_decode(nibble_c);
            end

            if (slot_end_c) begin
                cnt_d   = '0;
                digit_d = 2'(digit_q + 2'd1);
                state_d = ST_BLANK;
                fd_d    = frame_end_c;
                if (frame_end_c) begin
                    if (value_valid) begin
                        disp_d = value_in;
                        flag_d = 1'b0;
                    end else if (flag_q) begin
                        disp_d = pend_q;
                        flag_d = 1'b0;
                    end
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_DRIVE;
                end
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver with short slots (8 cycles, 2 blank).
// The reference model tracks the absolute scan position since the last
// reset/enable and derives digit, blank window and frame edges from it.
module tb_seven_seg_scan_driver;

    localparam int R = 8;
    localparam int B = 2;
    localparam int F = 4 * R;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] value_in;
    logic        value_valid;
    logic        blank_lz;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    int n_vec = 0;
    int n_err = 0;

    logic [6:0]  dec [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [15:0] lz_val [2]    = '{16'h0030, 16'h0000};
    logic [6:0]  lz_tab [2][4] = '{'{7'h40, 7'h30, 7'h7F, 7'h7F},
                                   '{7'h40, 7'h7F, 7'h7F, 7'h7F}};

    // Reference model state.
    int          pos;
    logic [15:0] m_disp, m_pend;
    bit          m_flag;
    logic [6:0]  exp_seg;
    logic [3:0]  exp_an;
    logic        exp_fd;

    always #5 clk = ~clk;

    seven_seg_scan_driver #(
        .REFRESH_CYCLES(R),
        .BLANK_CYCLES  (B)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .value_in   (value_in),
        .value_valid(value_valid),
        .blank_lz   (blank_lz),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    // Behavioural model: the edge at scan position p shows slot p/R, offset p%R.
    always @(posedge clk) begin : model
        int          dg, off;
        logic [15:0] hi;
        if (reset) begin
            pos = 0; m_disp = 16'h0; m_pend = 16'h0; m_flag = 0;
            exp_seg = 7'h7F; exp_an = 4'hF; exp_fd = 1'b0;
        end else if (!enable) begin
            if (value_valid) m_pend = value_in;
            m_disp = m_pend; m_flag = 0; pos = 0;
            exp_seg = 7'h7F; exp_an = 4'hF; exp_fd = 1'b0;
        end else begin
            dg  = (pos / R) % 4;
            off = pos % R;
            hi  = m_disp >> (4 * dg);
            if (off < B) begin
                exp_an = 4'hF; exp_seg = 7'h7F;
            end else begin
                exp_an  = ~(4'b0001 << dg);
                exp_seg = (blank_lz && dg != 0 && hi == 16'h0) ? 7'h7F : dec[hi[3:0]];
            end
            exp_fd = (off == R - 1) && (dg == 3);
            if (exp_fd) begin
                if (value_valid) m_disp = value_in;
                else if (m_flag) m_disp = m_pend;
                m_flag = 0;
                if (value_valid) m_pend = value_in;
            end else if (value_valid) begin
                m_pend = value_in; m_flag = 1;
            end
            pos++;
        end
    end

    task automatic test_reset();
        repeat (3) begin
            @(negedge clk);
            n_vec++;
            if (an !== 4'hF || seg !== 7'h7F || frame_done !== 1'b0) begin
                n_err++;
                $display("FAIL reset: an=%h seg=%h fd=%b, expected an=F seg=7F fd=0", an, seg, frame_done);
            end
        end
    endtask

    task automatic test_first_frame();
        int fd_cnt = 0;
        logic prev_fd = 1'b0;
        logic [3:0] s_an;
        logic [6:0] s_seg;
        bit chk;
        reset = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            n_vec++;
            if (seg !== exp_seg || an !== exp_an || frame_done !== exp_fd) begin
                n_err++;
                $display("FAIL first_frame k=%0d: seg=%h an=%h fd=%b, expected seg=%h an=%h fd=%b",
                         k, seg, an, frame_done, exp_seg, exp_an, exp_fd);
            end
            chk = 1;
            case (k)
                2:  begin s_an = 4'hF; s_seg = 7'h7F; end
                8:  begin s_an = 4'hE; s_seg = 7'h40; end
                40: begin s_an = 4'hE; s_seg = 7'h0E; end
                48: begin s_an = 4'hD; s_seg = 7'h08; end
                56: begin s_an = 4'hB; s_seg = 7'h24; end
                64: begin s_an = 4'h7; s_seg = 7'h79; end
                default: chk = 0;
            endcase
            if (chk) begin
                n_vec++;
                if (an !== s_an || seg !== s_seg) begin
                    n_err++;
                    $display("FAIL first_frame_spot k=%0d: an=%h seg=%h, expected an=%h seg=%h", k, an, seg, s_an, s_seg);
                end
            end
            if (frame_done) fd_cnt++;
            if (k > 1) begin
                n_vec++;
                if (frame_done && prev_fd) begin
                    n_err++;
                    $display("FAIL frame_done_double k=%0d: fd=1 twice, expected single pulse", k);
                end
            end
            prev_fd = frame_done;
            value_valid = (k == 4);
            value_in    = (k == 4) ? 16'h12AF : 16'h0000;
        end
        n_vec++;
        if (fd_cnt !== 2) begin
            n_err++;
            $display("FAIL frame_done_count: %0d pulses, expected 2", fd_cnt);
        end
    endtask

    task automatic test_update_overwrite();
        logic [15:0] v;
        int p;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            p = pos - 1;
            n_vec++;
            if (seg !== exp_seg || an !== exp_an || frame_done !== exp_fd) begin
                n_err++;
                $display("FAIL overwrite p=%0d: seg=%h an=%h fd=%b, expected seg=%h an=%h fd=%b",
                         p, seg, an, frame_done, exp_seg, exp_an, exp_fd);
            end
            if (p == 95 || p == 103) begin
                n_vec++;
                if ((p == 95 && (an !== 4'h7 || seg !== 7'h79)) || (p == 103 && (an !== 4'hE || seg !== 7'h78))) begin
                    n_err++;
                    $display("FAIL overwrite_spot p=%0d: an=%h seg=%h, expected %s", p, an, seg,
                             (p == 95) ? "an=7 seg=79" : "an=E seg=78");
                end
            end
            value_valid = (i == 10 || i == 11);
            value_in    = (i == 10) ? 16'h0005 : 16'h0007;
        end
        // Strobe coincident with the frame wrap is shown in the very next frame.
        v = 16'($urandom);
        for (int i = 0; i < F && (pos % F) != F - 1; i++) begin
            @(negedge clk);
            n_vec++;
            if (seg !== exp_seg || an !== exp_an || frame_done !== exp_fd) begin
                n_err++;
                $display("FAIL wrap_align: seg=%h an=%h fd=%b, expected seg=%h an=%h fd=%b",
                         seg, an, frame_done, exp_seg, exp_an, exp_fd);
            end
        end
        value_valid = 1'b1; value_in = v;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            value_valid = 1'b0;
            n_vec++;
            if (seg !== exp_seg || an !== exp_an || frame_done !== exp_fd) begin
                n_err++;
                $display("FAIL wrap_strobe i=%0d: seg=%h an=%h fd=%b, expected seg=%h an=%h fd=%b",
                         i, seg, an, frame_done, exp_seg, exp_an, exp_fd);
            end
            if (i == 8) begin
                n_vec++;
                if (an !== 4'hE || seg !== dec[v[3:0]]) begin
                    n_err++;
                    $display("FAIL wrap_strobe_spot: an=%h seg=%h, expected an=E seg=%h", an, seg, dec[v[3:0]]);
                end
            end
        end
    endtask

    task automatic test_blank_lz();
        logic [3:0] s_an;
        blank_lz = 1'b1;
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < F && (pos % F) != F - 1; i++) begin
                @(negedge clk);
                n_vec++;
                if (seg !== exp_seg || an !== exp_an || frame_done !== exp_fd) begin
                    n_err++;
                    $display("FAIL lz_align: seg=%h an=%h fd=%b, expected seg=%h an=%h fd=%b",
                             seg, an, frame_done, exp_seg, exp_an, exp_fd);
                end
            end
            value_valid = 1'b1; value_in = lz_val[t];
            for (int i = 0; i < F; i++) begin
                @(negedge clk);
                value_valid = 1'b0;
                n_vec++;
                if (seg !== exp_seg || an !== exp_an || frame_done !== exp_fd) begin
                    n_err++;
                    $display("FAIL lz i=%0d: seg=%h an=%h fd=%b, expected seg=%h an=%h fd=%b",
                             i, seg, an, frame_done, exp_seg, exp_an, exp_fd);
                end
                if (i % R == R - 1) begin
                    s_an = ~(4'b0001 << (i / R));
                    n_vec++;
                    if (an !== s_an || seg !== lz_tab[t][i / R]) begin
                        n_err++;
                        $display("FAIL lz_spot value=%h digit=%0d: an=%h seg=%h, expected an=%h seg=%h",
                                 lz_val[t], i / R, an, seg, s_an, lz_tab[t][i / R]);
                    end
                end
            end
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_enable_drop();
        logic [15:0] v = 16'($urandom);
        for (int i = 0; i < F && (pos % F) != 2 * R + 4; i++) begin
            @(negedge clk);
            n_vec++;
            if (seg !== exp_seg || an !== exp_an || frame_done !== exp_fd) begin
                n_err++;
                $display("FAIL en_align: seg=%h an=%h fd=%b, expected seg=%h an=%h fd=%b",
                         seg, an, frame_done, exp_seg, exp_an, exp_fd);
            end
        end
        n_vec++;
        if (an !== 4'hB) begin
            n_err++;
            $display("FAIL en_mid_digit2: an=%h, expected an=B", an);
        end
        enable = 1'b0; value_valid = 1'b1; value_in = v;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            value_valid = 1'b0;
            n_vec++;
            if (seg !== exp_seg || an !== exp_an || frame_done !== exp_fd) begin
                n_err++;
                $display("FAIL enable i=%0d: seg=%h an=%h fd=%b, expected seg=%h an=%h fd=%b",
                         i, seg, an, frame_done, exp_seg, exp_an, exp_fd);
            end
            if (i == 1 || i == 5 || i == 6 || i == 7) begin
                n_vec++;
                if (an !== ((i == 7) ? 4'hE : 4'hF) || seg !== ((i == 7) ? dec[v[3:0]] : 7'h7F)) begin
                    n_err++;
                    $display("FAIL enable_spot i=%0d: an=%h seg=%h, expected an=%h seg=%h", i, an, seg,
                             (i == 7) ? 4'hE : 4'hF, (i == 7) ? dec[v[3:0]] : 7'h7F);
                end
            end
            if (i == 4) enable = 1'b1;
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] v = 16'($urandom) | 16'h0001;
        for (int i = 0; i < R && (pos % R) != 5; i++) begin
            @(negedge clk);
            n_vec++;
            if (seg !== exp_seg || an !== exp_an || frame_done !== exp_fd) begin
                n_err++;
                $display("FAIL rst_align: seg=%h an=%h fd=%b, expected seg=%h an=%h fd=%b",
                         seg, an, frame_done, exp_seg, exp_an, exp_fd);
            end
        end
        value_valid = 1'b1; value_in = v;
        @(negedge clk);
        value_valid = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_vec++;
        if (an !== 4'hF || seg !== 7'h7F || frame_done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: an=%h seg=%h fd=%b, expected an=F seg=7F fd=0", an, seg, frame_done);
        end
        for (int i = 1; i <= 2 * F; i++) begin
            @(negedge clk);
            n_vec++;
            if (seg !== exp_seg || an !== exp_an || frame_done !== exp_fd) begin
                n_err++;
                $display("FAIL reset_mid i=%0d: seg=%h an=%h fd=%b, expected seg=%h an=%h fd=%b",
                         i, seg, an, frame_done, exp_seg, exp_an, exp_fd);
            end
            if ((i - 1) % R >= B) begin
                n_vec++;
                if (seg !== 7'h40) begin
                    n_err++;
                    $display("FAIL reset_mid_discard i=%0d: seg=%h, expected seg=40", i, seg);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            n_vec++;
            if (seg !== exp_seg || an !== exp_an || frame_done !== exp_fd) begin
                n_err++;
                $display("FAIL random i=%0d: seg=%h an=%h fd=%b, expected seg=%h an=%h fd=%b",
                         i, seg, an, frame_done, exp_seg, exp_an, exp_fd);
            end
            value_valid = ($urandom_range(9) == 0);
            value_in    = 16'($urandom) >> $urandom_range(15);
            if ($urandom_range(49) == 0) blank_lz = ~blank_lz;
            if ($urandom_range(99) == 0) enable = ~enable;
            if (!enable && $urandom_range(9) == 0) enable = 1'b1;
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; value_in = 16'h0000; value_valid = 1'b0; blank_lz = 1'b0;
        test_reset();
        test_first_frame();
        test_update_overwrite();
        test_blank_lz();
        test_enable_drop();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
